// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: default widths, PC step, bubble encoding
// and the fetch-state encoding used by the IF stage.
package cpu_pkg;
  localparam int CPU_ADDR_W  = 64;
  localparam int CPU_INSTR_W = 32;
  localparam int PC_INCR     = 4;
  localparam logic [CPU_INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetchState_t;
endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: synchronous reset, flush, load enable and a
// bubble input that turns the slot into a NOP while keeping its PC.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic               bubble,
  input  logic [ADDR_W-1:0]  pcIn,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic               validIn,
  output logic [ADDR_W-1:0]  pcOut,
  output logic [INSTR_W-1:0] instrOut,
  output logic               validOut
);

  // Reset and flush both clear the whole slot; a bubble only kills the
  // instruction so the held PC stays visible to decode.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      pcOut    <= '0;
      instrOut <= INSTR_W'(NOP_INSTR);
      validOut <= 1'b0;
    end else if (load) begin
      pcOut    <= pcIn;
      instrOut <= instrIn;
      validOut <= validIn;
    end else if (bubble) begin
      instrOut <= INSTR_W'(NOP_INSTR);
      validOut <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: PC, two-state fetch FSM and a one-entry
// skid buffer that catches an instruction returning during a stall.
module if_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                INSTR_W  = CPU_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               PCWire,
  input  logic               IFID_Write,
  input  logic               Branch_Taken,
  input  logic [ADDR_W-1:0]  Branch_Target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  IFID_PC,
  output logic [INSTR_W-1:0] IFID_Instruction,
  output logic               IFID_Valid
);

  fetchState_t        state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  bufPc;
  logic [INSTR_W-1:0] bufInstr;
  logic               bufValid;
  logic               reqReg;
  logic               adv;

  logic               ifidLoad;
  logic               ifidBubble;
  logic [ADDR_W-1:0]  ifidPcIn;
  logic [INSTR_W-1:0] ifidInstrIn;
  logic               ifidValidIn;

  assign adv       = PCWire & IFID_Write;
  assign imem_req  = reqReg;
  assign imem_addr = pc;

  // A ready response that cannot advance is parked in the skid buffer and
  // fetching pauses until the hazard unit releases the pipeline.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= S_REQ;
      reqReg   <= 1'b1;
      pc       <= RESET_PC;
      bufPc    <= '0;
      bufInstr <= '0;
      bufValid <= 1'b0;
    end else if (Branch_Taken) begin
      state    <= S_REQ;
      reqReg   <= 1'b1;
      pc       <= Branch_Target;
      bufValid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready) begin
            if (adv) begin
              pc <= pc + ADDR_W'(PC_INCR);
            end else begin
              bufPc    <= pc;
              bufInstr <= imem_rdata;
              bufValid <= 1'b1;
              state    <= S_HOLD;
              reqReg   <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (adv) begin
            pc       <= pc + ADDR_W'(PC_INCR);
            bufValid <= 1'b0;
            state    <= S_REQ;
            reqReg   <= 1'b1;
          end
        end
        default: begin
          state  <= S_REQ;
          reqReg <= 1'b1;
        end
      endcase
    end
  end

  // IF/ID source selection: the skid buffer drains first, otherwise the
  // live memory response; a missing response under advance is a bubble.
  always_comb begin
    ifidLoad    = 1'b0;
    ifidBubble  = 1'b0;
    ifidPcIn    = pc;
    ifidInstrIn = imem_rdata;
    ifidValidIn = 1'b1;
    if (state == S_HOLD) begin
      ifidLoad    = adv;
      ifidPcIn    = bufPc;
      ifidInstrIn = bufInstr;
      ifidValidIn = bufValid;
    end else if (imem_ready) begin
      ifidLoad = adv;
    end else begin
      ifidBubble = adv;
    end
  end

  ifid_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) ifidReg (
    .clock   (CLOCK),
    .reset   (RESET),
    .load    (ifidLoad),
    .flush   (Branch_Taken),
    .bubble  (ifidBubble),
    .pcIn    (ifidPcIn),
    .instrIn (ifidInstrIn),
    .validIn (ifidValidIn),
    .pcOut   (IFID_PC),
    .instrOut(IFID_Instruction),
    .validOut(IFID_Valid)
  );

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LEGv8 pipeline: holds the PC, issues instruction-memory reads, and drives the IF/ID pipeline register.
- Directly upstream of the hazard detection unit. Consumes that unit's PCWire / IFID_Write stall outputs and the EX/MEM branch redirect.
- Produces IFID_PC, IFID_Instruction and IFID_Valid, which decode and hazard detection read.
- Contains a 2-state fetch FSM and a 1-entry skid buffer so that an instruction returning during a stall is never lost.

Parameters:
- ADDR_W, 64, PC / memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 64'h0, PC value after reset

Ports:
- CLOCK  input  1  single clock; all state updates on the rising edge
- RESET  input  1  synchronous, active-high reset
- PCWire  input  1  1 = PC may advance (from hazard unit)
- IFID_Write  input  1  1 = IF/ID may load (from hazard unit)
- Branch_Taken  input  1  redirect / flush request (from EX/MEM)
- Branch_Target  input  ADDR_W  redirect address
- imem_req  output  1  fetch request
- imem_addr  output  ADDR_W  fetch address
- imem_ready  input  1  imem_rdata is valid for imem_addr this cycle
- imem_rdata  input  INSTR_W  fetched instruction
- IFID_PC  output  ADDR_W  PC of instruction in IF/ID
- IFID_Instruction  output  INSTR_W  instruction in IF/ID; 0 = NOP/bubble
- IFID_Valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset is synchronous and active-high and is sampled only on the rising CLOCK edge. On reset:
  - pc = RESET_PC and state = S_REQ;
  - IFID_PC = 0, IFID_Instruction = 0, IFID_Valid = 0;
  - buffer valid = 0.
- Reset mid-request discards everything; the first request after reset is at RESET_PC on the following cycle.
- Memory protocol:
  - Combinational response: imem_ready may be asserted in the same cycle as imem_req for the address presented.
  - imem_addr may change on any cycle; there are no outstanding-transaction semantics.
  - imem_ready is ignored while imem_req = 0.
- Outputs by state:
  - imem_req = 1 in S_REQ, 0 in S_HOLD.
  - imem_addr = pc at all times.
- Advance condition: adv = PCWire & IFID_Write. Any other combination is a full stall, with PC and IF/ID both held.
- Priority, highest first: RESET, Branch_Taken, normal operation.
- Branch_Taken = 1 (any state, regardless of adv):
  - pc <= Branch_Target;
  - IFID_Valid <= 0, IFID_Instruction <= 0, IFID_PC <= 0;
  - buffer invalidated and state <= S_REQ;
  - any imem_ready/rdata in the same cycle is discarded.
- S_REQ with imem_ready = 1 and adv = 1:
  - IF/ID <= {pc, imem_rdata, valid = 1};
  - pc <= pc + 4 (wraps modulo 2^ADDR_W);
  - stay in S_REQ. Sustained throughput is 1 instruction per cycle.
- S_REQ with imem_ready = 1 and adv = 0:
  - buffer <= {pc, imem_rdata}; pc unchanged;
  - IF/ID held; state <= S_HOLD.
- S_REQ with imem_ready = 0:
  - adv = 1: IFID_Valid <= 0 and IFID_Instruction <= 0 (bubble); pc held.
  - adv = 0: IF/ID held.
- S_HOLD with adv = 1:
  - IF/ID <= {buffer, valid = 1};
  - pc <= pc + 4; buffer invalidated;
  - state <= S_REQ.
- S_HOLD with adv = 0: hold everything.
- Latency: an instruction accepted at edge N is visible on the IF/ID outputs after edge N. There is no combinational path from imem_rdata to the IFID_* outputs.

Decomposition:
- Shared package (cpu_pkg) holds:
  - ADDR_W and INSTR_W defaults;
  - PC_INCR = 4;
  - NOP_INSTR = 0;
  - the fetch-state encoding (S_REQ = 1'b0, S_HOLD = 1'b1).
- One natural sub-module: ifid_reg, the IF/ID register with synchronous reset, load enable and flush. It is reused by the other pipeline registers' pattern.
- The PC, FSM and skid buffer stay in if_stage.

Test Plan:
1. Reset, then imem_ready = 1 constantly with adv = 1 -> addresses 0, 4, 8, 12 on consecutive cycles; IFID_PC follows one cycle later with IFID_Valid = 1.
2. Stall (PCWire = IFID_Write = 0) for 3 cycles while ready = 1 at pc = 8 -> state enters S_HOLD, imem_req = 0, IF/ID held at PC 4.
   - On release: IFID_PC = 8 with the buffered instruction, next request at 12, no instruction lost or duplicated.
3. Branch_Taken = 1 with target 0x100 while in S_HOLD:
   - buffer dropped, IFID_Valid = 0, IFID_Instruction = 0;
   - next imem_addr = 0x100, then IFID_PC = 0x100.
4. Branch_Taken together with a stall and ready = 1 at pc = 0x20 -> the branch wins, rdata is discarded, pc = Branch_Target.
5. imem_ready = 0 for 2 cycles with adv = 1 -> two bubbles (IFID_Valid = 0) and pc held; with adv = 0 the IF/ID contents are held instead.
6. Assert RESET while in S_HOLD with pc = 0x40 -> the next cycle shows pc = RESET_PC, IFID_Valid = 0, imem_req = 1.
   - Also check wrap: pc = 2^64 − 4 advances to 0.
